// File: rtl/host_uart_initiator.sv
// Host-side UART command initiator: serialises a command word LSB-byte first and
// optionally collects a response word, reporting timeout or framing errors.
module host_uart_initiator #(
  parameter int CLK_FREQ       = 25000000,
  parameter int BIT_RATE       = 115200,
  parameter int WORD_SIZE_BY   = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [8*WORD_SIZE_BY-1:0] cmd_word,
  input  logic                      expect_resp,
  output logic                      tx,
  input  logic                      rx,
  output logic                      resp_valid,
  output logic [8*WORD_SIZE_BY-1:0] resp_word,
  output logic                      timeout,
  output logic                      frame_err
);
  localparam int CPB = CLK_FREQ / BIT_RATE;
  localparam int WW  = 8 * WORD_SIZE_BY;
  localparam int CW  = $clog2(CPB);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW  = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [BW-1:0] byte_idx;
  logic [TW-1:0] to_cnt;
  logic [WW-1:0] tx_sh, rx_sh;
  logic          exp_q, tx_q;
  logic          rx_meta, rx_sync, rx_prev;
  logic          bit_end, half_end, last_bit, last_byte, rx_fall, to_hit;

  assign bit_end   = (cnt == CW'(CPB - 1));
  assign half_end  = (cnt == CW'(CPB / 2 - 1));
  assign last_bit  = (bit_idx == 3'd7);
  assign last_byte = (byte_idx == BW'(WORD_SIZE_BY - 1));
  assign rx_fall   = rx_prev & ~rx_sync;
  assign to_hit    = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign tx        = tx_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = TX_START;
      end
      TX_START: if (bit_end) state_n = TX_DATA;
      TX_DATA:  if (bit_end && last_bit) state_n = TX_STOP;
      TX_STOP:  if (bit_end) state_n = !last_byte ? TX_START : (exp_q ? RX_WAIT : IDLE);
      // a start edge wins over a coincident timeout
      RX_WAIT:  if (rx_fall) state_n = RX_START;
                else if (to_hit) state_n = IDLE;
      RX_START: if (half_end) state_n = rx_sync ? RX_WAIT : RX_DATA;
      RX_DATA:  if (bit_end && last_bit) state_n = RX_STOP;
      RX_STOP:  if (bit_end) state_n = (rx_sync && !last_byte) ? RX_WAIT : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      to_cnt     <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      exp_q      <= 1'b0;
      tx_q       <= 1'b1;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      resp_word  <= '0;
      resp_valid <= 1'b0;
      timeout    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      resp_valid <= 1'b0;
      timeout    <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            tx_sh    <= cmd_word;
            exp_q    <= expect_resp;
            tx_q     <= 1'b0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        // tx_sh shifts once per data bit so the next byte lands at bit 0
        TX_START: begin
          cnt <= bit_end ? '0 : cnt + CW'(1);
          if (bit_end) begin
            tx_q    <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            bit_idx <= '0;
          end
        end
        TX_DATA: begin
          cnt <= bit_end ? '0 : cnt + CW'(1);
          if (bit_end) begin
            if (last_bit) begin
              tx_q    <= 1'b1;
              bit_idx <= '0;
            end else begin
              tx_q    <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        TX_STOP: begin
          cnt <= bit_end ? '0 : cnt + CW'(1);
          if (bit_end) begin
            if (!last_byte) begin
              byte_idx <= byte_idx + BW'(1);
              tx_q     <= 1'b0;
            end else begin
              byte_idx <= '0;
            end
          end
        end
        RX_WAIT: begin
          cnt <= '0;
          if (rx_fall) to_cnt <= '0;
          else if (to_hit) begin
            timeout  <= 1'b1;
            to_cnt   <= '0;
            byte_idx <= '0;
          end else to_cnt <= to_cnt + TW'(1);
        end
        RX_START: begin
          cnt <= half_end ? '0 : cnt + CW'(1);
          if (half_end) bit_idx <= '0;
        end
        RX_DATA: begin
          cnt <= bit_end ? '0 : cnt + CW'(1);
          if (bit_end) begin
            rx_sh   <= {rx_sync, rx_sh[WW-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        RX_STOP: begin
          cnt <= bit_end ? '0 : cnt + CW'(1);
          if (bit_end) begin
            if (!rx_sync) begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
            end else if (last_byte) begin
              resp_word  <= rx_sh;
              resp_valid <= 1'b1;
              byte_idx   <= '0;
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: doc/host_uart_initiator.md
HOST_UART_INITIATOR -- requirements
Module: host_uart_initiator

Interface
- REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
  - CLK_FREQ, 25000000, clock frequency in Hz.
  - BIT_RATE, 115200, UART baud rate.
  - WORD_SIZE_BY, 4, bytes per command/response word.
  - TIMEOUT_CYCLES, 1000000, maximum number of idle cycles to wait for a response.
- REQ-002 The derived constant CPB SHALL equal CLK_FREQ/BIT_RATE (integer division); CPB SHALL be at least 4.
- REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  - clk, in, 1, sole clock.
  - reset, in, 1, asynchronous, active-high.
  - cmd_valid, in, 1, a command word is offered.
  - cmd_ready, out, 1, the block can accept a command.
  - cmd_word, in, 8*WORD_SIZE_BY, command to transmit.
  - expect_resp, in, 1, wait for a response word after sending (sampled with the command).
  - tx, out, 1, serial line driven toward the controller rx.
  - rx, in, 1, serial line from the controller tx.
  - resp_valid, out, 1, one-cycle pulse: resp_word is valid.
  - resp_word, out, 8*WORD_SIZE_BY, assembled response.
  - timeout, out, 1, one-cycle pulse: response not received in time.
  - frame_err, out, 1, one-cycle pulse: a received stop bit was 0.

Function
- REQ-004 A command SHALL be accepted on a rising clk edge where cmd_valid=1 and cmd_ready=1; cmd_word and expect_resp SHALL be latched at that edge.
- REQ-005 cmd_ready SHALL be 1 only in state IDLE.
- REQ-006 The FSM states SHALL be IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP.
- REQ-007 Each transmitted byte SHALL consist of 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1); each bit SHALL be held for exactly CPB cycles.
- REQ-008 Bytes SHALL be sent least-significant byte first (byte 0 = cmd_word[7:0]).
- REQ-009 Consecutive bytes SHALL be back-to-back, with no idle gap after a stop bit.
- REQ-010 tx SHALL change on the clock edge following acceptance; the whole command SHALL occupy exactly 10*CPB*WORD_SIZE_BY cycles.
- REQ-011 After the last stop bit, the FSM SHALL go to IDLE if expect_resp=0, else to RX_WAIT.
- REQ-012 rx SHALL pass through a 2-flop synchronizer; all receive decisions SHALL use the synchronized value.
- REQ-013 In RX_WAIT, a synchronized 1->0 transition SHALL enter RX_START.
- REQ-014 RX_START SHALL re-sample the line at CPB/2 cycles; if it reads 1 (false start), the FSM SHALL return to RX_WAIT without consuming a byte.
- REQ-015 After a valid start bit, data bits SHALL be sampled every CPB cycles, then the stop bit; bytes SHALL be assembled LSB first into resp_word, byte 0 lowest.
- REQ-016 If a stop bit samples 0, frame_err SHALL pulse, the partial word SHALL be discarded, and the FSM SHALL go to IDLE.
- REQ-017 After WORD_SIZE_BY good bytes, resp_word SHALL be updated and resp_valid SHALL pulse in the same cycle the FSM enters IDLE.
- REQ-018 The timeout counter SHALL count cycles spent in RX_WAIT and reset to 0 on every byte start.
- REQ-019 When the timeout counter reaches TIMEOUT_CYCLES, timeout SHALL pulse, the partial word SHALL be discarded, and the FSM SHALL go to IDLE.
- REQ-020 resp_valid, timeout and frame_err SHALL be mutually exclusive and SHALL each be 1 cycle wide.
- REQ-021 resp_word SHALL hold its last valid value until the next successful response.
- REQ-022 rx activity while transmitting SHALL be ignored.
- REQ-023 cmd_valid while busy SHALL be ignored and SHALL NOT be queued.

Reset
- REQ-024 While reset=1 the block SHALL hold the following values: FSM = IDLE, tx=1, cmd_ready=1, resp_valid=0, timeout=0, frame_err=0, resp_word=0, all counters 0, synchronizer flops=1.
- REQ-025 Reset asserted mid-byte SHALL return tx to 1 immediately (asynchronously) and discard all in-flight state.
- REQ-026 The first command after deassertion SHALL be accepted on the first edge with cmd_valid=1.

Verification (CLK_FREQ=8, BIT_RATE=1, so CPB=8; WORD_SIZE_BY=4; TIMEOUT_CYCLES=200)
- REQ-027 Send cmd_word=32'h0000004A with expect_resp=0 -> tx carries bytes 4A,00,00,00 framed over exactly 320 cycles; cmd_ready returns to 1 at cycle 320.
- REQ-028 Send any command with expect_resp=1, then a bench UART drives bytes 78,56,34,12 on rx -> resp_valid pulses once with resp_word=32'h12345678.
- REQ-029 Send a command with expect_resp=1 and leave rx idle -> timeout pulses exactly once, 200 cycles after entering RX_WAIT; resp_word is unchanged.
- REQ-030 Drive a 3-cycle 0 glitch on rx in RX_WAIT, then a valid word -> no byte is consumed by the glitch; the valid word is then received correctly.
- REQ-031 Drive the second response byte with stop bit 0 -> frame_err pulses, resp_valid stays 0, FSM returns to IDLE.
- REQ-032 Assert reset during data bit 3 of byte 1 -> tx=1 in the same cycle; after release, a new command transmits correctly from byte 0.
